// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the memory-stage load/store controller:
// memory op codes, FSM states and op classification helpers.
package mem_lsu_ctrl_pkg;

  typedef enum logic [3:0] {
    MEMOP_NOP = 4'd0,
    MEMOP_LB  = 4'd1,
    MEMOP_LBU = 4'd2,
    MEMOP_LH  = 4'd3,
    MEMOP_LHU = 4'd4,
    MEMOP_LW  = 4'd5,
    MEMOP_SB  = 4'd6,
    MEMOP_SH  = 4'd7,
    MEMOP_SW  = 4'd8,
    MEMOP_LL  = 4'd9,
    MEMOP_SC  = 4'd10
  } memop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_HOLD = 2'd2
  } lsu_state_t;

  localparam int unsigned LSU_BUS_TIMEOUT = 255;

  function automatic logic is_mem_op(memop_t op);
    return op inside {MEMOP_LB, MEMOP_LBU, MEMOP_LH, MEMOP_LHU, MEMOP_LW,
                      MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_LL, MEMOP_SC};
  endfunction

  // SC counts as a store for bus direction and address-error class.
  function automatic logic is_store(memop_t op);
    return op inside {MEMOP_SB, MEMOP_SH, MEMOP_SW, MEMOP_SC};
  endfunction

  function automatic logic is_misaligned(memop_t op, logic [1:0] off);
    logic r;
    r = 1'b0;
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH:       r = off[0];
      MEMOP_LW, MEMOP_LL, MEMOP_SW, MEMOP_SC: r = (off != 2'b00);
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_lsu_ctrl_lane_align.sv
// Big-endian byte-lane handling: request lane selects and store replication,
// plus extraction and sign/zero extension of returned load data.
module mem_lane_align
  import mem_lsu_ctrl_pkg::*;
(
  input  memop_t      i_req_op,
  input  logic [1:0]  i_req_off,
  input  logic [31:0] i_sdata,
  output logic [3:0]  o_sel,
  output logic [31:0] o_wdata,
  input  memop_t      i_rsp_op,
  input  logic [1:0]  i_rsp_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_sel   = 4'b1111;
    o_wdata = i_sdata;
    case (i_req_op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: begin
        o_sel   = 4'b1000 >> i_req_off;
        o_wdata = {4{i_sdata[7:0]}};
      end
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: begin
        o_sel   = i_req_off[1] ? 4'b0011 : 4'b1100;
        o_wdata = {2{i_sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = 8'h00;
    case (i_rsp_off)
      2'd0: w_byte = i_rdata[31:24];
      2'd1: w_byte = i_rdata[23:16];
      2'd2: w_byte = i_rdata[15:8];
      2'd3: w_byte = i_rdata[7:0];
      default: ;
    endcase
    w_half = i_rsp_off[1] ? i_rdata[15:0] : i_rdata[31:16];
    case (i_rsp_op)
      MEMOP_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
      MEMOP_LBU: o_ldata = {24'h000000, w_byte};
      MEMOP_LH:  o_ldata = {{16{w_half[15]}}, w_half};
      MEMOP_LHU: o_ldata = {16'h0000, w_half};
      default:   o_ldata = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Memory-stage load/store controller: issues ack-based bus accesses, stalls
// the pipeline while they are in flight and produces write-back / LL-bit data.
module mem_lsu_ctrl
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = LSU_BUS_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [3:0]  memop_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we_i,
  input  logic        wb_LLbit_value_i,
  input  logic        dbus_ack_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        dbus_cyc_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_sel_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        stallreq_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        buserr_o
);

  lsu_state_t  r_state;
  logic        r_cyc;
  logic        r_we;
  logic [3:0]  r_sel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_cnt;
  logic        r_kill;
  memop_t      r_op;
  logic [1:0]  r_off;
  logic [4:0]  r_wd;
  logic        r_wreg;
  logic [31:0] r_result;
  logic        r_llwe;
  logic        r_llval;

  memop_t      w_op;
  logic        w_llbit;
  logic        w_is_mem;
  logic        w_store;
  logic        w_misal;
  logic        w_sc_fail;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_sel;
  logic [31:0] w_wdata;
  logic [31:0] w_ldata;

  assign w_op      = memop_t'(memop_i);
  assign w_llbit   = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
  assign w_is_mem  = valid_i && is_mem_op(w_op);
  assign w_store   = is_store(w_op);
  assign w_misal   = is_misaligned(w_op, addr_i[1:0]);
  assign w_sc_fail = (w_op == MEMOP_SC) && !w_llbit;
  assign w_start   = (r_state == ST_IDLE) && w_is_mem && !w_misal && !w_sc_fail && !flush;
  // Terminal count is the BUS_TIMEOUT-th BUS cycle; an ack in that cycle wins.
  assign w_timeout = (r_state == ST_BUS) && !dbus_ack_i && (BUS_TIMEOUT != 0) &&
                     (r_cnt == BUS_TIMEOUT - 1);

  mem_lane_align u_align (
    .i_req_op  (w_op),
    .i_req_off (addr_i[1:0]),
    .i_sdata   (sdata_i),
    .o_sel     (w_sel),
    .o_wdata   (w_wdata),
    .i_rsp_op  (r_op),
    .i_rsp_off (r_off),
    .i_rdata   (dbus_rdata_i),
    .o_ldata   (w_ldata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cyc    <= 1'b0;
      r_we     <= 1'b0;
      r_sel    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_cnt    <= '0;
      r_kill   <= 1'b0;
      r_op     <= MEMOP_NOP;
      r_off    <= '0;
      r_wd     <= '0;
      r_wreg   <= 1'b0;
      r_result <= '0;
      r_llwe   <= 1'b0;
      r_llval  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_kill <= 1'b0;
          if (w_start) begin
            r_state <= ST_BUS;
            r_cyc   <= 1'b1;
            r_we    <= w_store;
            r_sel   <= w_sel;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_wdata <= w_wdata;
            r_cnt   <= '0;
            r_op    <= w_op;
            r_off   <= addr_i[1:0];
            r_wd    <= wd_i;
          end
        end
        ST_BUS: begin
          r_cnt <= r_cnt + 32'd1;
          if (flush) r_kill <= 1'b1;
          if (dbus_ack_i) begin
            r_state  <= ST_HOLD;
            r_cyc    <= 1'b0;
            r_we     <= 1'b0;
            r_sel    <= '0;
            r_result <= (r_op == MEMOP_SC) ? 32'd1 : w_ldata;
            r_wreg   <= !is_store(r_op) || (r_op == MEMOP_SC);
            r_llwe   <= (r_op == MEMOP_LL) || (r_op == MEMOP_SC);
            r_llval  <= (r_op == MEMOP_LL);
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= '0;
            r_kill  <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_state <= ST_IDLE;
          r_kill  <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    stallreq_o    = 1'b0;
    adel_o        = 1'b0;
    ades_o        = 1'b0;
    buserr_o      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mem) begin
          wreg_o = 1'b0;
          if (w_misal) begin
            adel_o = !w_store;
            ades_o = w_store;
          end else if (w_sc_fail) begin
            wreg_o  = 1'b1;
            wdata_o = '0;
          end else begin
            stallreq_o = 1'b1;
          end
        end
      end
      ST_BUS: begin
        wd_o    = r_wd;
        wreg_o  = 1'b0;
        wdata_o = '0;
        if (w_timeout) buserr_o = !r_kill;
        else           stallreq_o = 1'b1;
      end
      ST_HOLD: begin
        wd_o          = r_wd;
        wreg_o        = r_wreg && !r_kill;
        wdata_o       = r_result;
        LLbit_we_o    = r_llwe && !r_kill;
        LLbit_value_o = r_llval && r_llwe && !r_kill;
      end
      default: ;
    endcase
    // A flush never aborts an in-flight access, so the BUS stall is kept.
    if (flush) begin
      wreg_o        = 1'b0;
      LLbit_we_o    = 1'b0;
      LLbit_value_o = 1'b0;
      adel_o        = 1'b0;
      ades_o        = 1'b0;
      buserr_o      = 1'b0;
      if (r_state == ST_IDLE) stallreq_o = 1'b0;
    end
    if (!rst) begin
      wd_o          = '0;
      wreg_o        = 1'b0;
      wdata_o       = '0;
      LLbit_we_o    = 1'b0;
      LLbit_value_o = 1'b0;
      stallreq_o    = 1'b0;
      adel_o        = 1'b0;
      ades_o        = 1'b0;
      buserr_o      = 1'b0;
    end
  end

  assign dbus_cyc_o   = r_cyc;
  assign dbus_we_o    = r_we;
  assign dbus_sel_o   = r_sel;
  assign dbus_addr_o  = r_addr;
  assign dbus_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Directed bench for mem_lsu_ctrl with a short bus timeout.
module tb_mem_lsu_ctrl;
  import mem_lsu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, valid_i;
  logic [3:0]  memop_i;
  logic [31:0] addr_i, sdata_i, wdata_i, dbus_rdata_i;
  logic [4:0]  wd_i;
  logic        wreg_i, LLbit_i, wb_LLbit_we_i, wb_LLbit_value_i, dbus_ack_i;
  logic        dbus_cyc_o, dbus_we_o;
  logic [3:0]  dbus_sel_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, wdata_o;
  logic [4:0]  wd_o;
  logic        wreg_o, LLbit_we_o, LLbit_value_o, stallreq_o, adel_o, ades_o, buserr_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.BUS_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .memop_i(memop_i),
    .addr_i(addr_i), .sdata_i(sdata_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
    .LLbit_i(LLbit_i), .wb_LLbit_we_i(wb_LLbit_we_i), .wb_LLbit_value_i(wb_LLbit_value_i),
    .dbus_ack_i(dbus_ack_i), .dbus_rdata_i(dbus_rdata_i),
    .dbus_cyc_o(dbus_cyc_o), .dbus_we_o(dbus_we_o), .dbus_sel_o(dbus_sel_o),
    .dbus_addr_o(dbus_addr_o), .dbus_wdata_o(dbus_wdata_o),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .LLbit_we_o(LLbit_we_o), .LLbit_value_o(LLbit_value_o), .stallreq_o(stallreq_o),
    .adel_o(adel_o), .ades_o(ades_o), .buserr_o(buserr_o)
  );

  task automatic drive_op(input memop_t op, input logic [31:0] a, input logic [31:0] sd);
    valid_i = 1'b1; memop_i = op; addr_i = a; sdata_i = sd;
    wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'h0000_5A5A;
  endtask

  task automatic drive_idle();
    valid_i = 1'b0; memop_i = MEMOP_NOP; addr_i = '0; sdata_i = '0;
  endtask

  // One access acked on its first BUS cycle; returns what was observed.
  task automatic run_access(input memop_t op, input logic [31:0] a, input logic [31:0] sd,
                            input logic [31:0] rd, output logic [3:0] sel, output logic we,
                            output logic [31:0] baddr, output logic [31:0] bwdata,
                            output logic hwreg, output logic [31:0] hwdata,
                            output logic hllwe, output logic hllval);
    @(posedge clk); #1; drive_op(op, a, sd);
    @(negedge clk);
    @(posedge clk); #1; dbus_ack_i = 1'b1; dbus_rdata_i = rd;
    @(negedge clk); sel = dbus_sel_o; we = dbus_we_o; baddr = dbus_addr_o; bwdata = dbus_wdata_o;
    @(posedge clk); #1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    @(negedge clk); hwreg = wreg_o; hwdata = wdata_o; hllwe = LLbit_we_o; hllval = LLbit_value_o;
    @(posedge clk); #1; drive_idle();
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; valid_i = 1'b1; memop_i = MEMOP_NOP; addr_i = '0; sdata_i = '0;
    wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h55; LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0;
    wb_LLbit_value_i = 1'b0; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    #2;
    n_total++; if ({dbus_cyc_o, dbus_we_o, dbus_sel_o} !== 6'b0) $display("FAIL rst_bus got %b exp 0", {dbus_cyc_o, dbus_we_o, dbus_sel_o}); else n_pass++;
    n_total++; if ({dbus_addr_o, dbus_wdata_o} !== 64'h0) $display("FAIL rst_addr_wdata got %h exp 0", {dbus_addr_o, dbus_wdata_o}); else n_pass++;
    n_total++; if ({wreg_o, wdata_o, wd_o, stallreq_o, LLbit_we_o} !== 40'h0) $display("FAIL rst_wb got %h exp 0", {wreg_o, wdata_o, wd_o, stallreq_o, LLbit_we_o}); else n_pass++;
    @(posedge clk); @(posedge clk); #1; rst = 1'b1; wdata_i = 32'hCAFE; valid_i = 1'b0;
    @(negedge clk);
    n_total++; if ({wreg_o, wdata_o, wd_o} !== {1'b1, 32'hCAFE, 5'd3}) $display("FAIL passthru got %h exp %h", {wreg_o, wdata_o, wd_o}, {1'b1, 32'hCAFE, 5'd3}); else n_pass++;
  endtask

  task automatic test_lw();
    int unsigned stalls;
    stalls = 0;
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0); wd_i = 5'd5;
    @(negedge clk); if (stallreq_o) stalls++;
    n_total++; if (dbus_cyc_o !== 1'b0) $display("FAIL lw_cyc_issue got %b exp 0", dbus_cyc_o); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin dbus_ack_i = 1'b1; dbus_rdata_i = 32'hDEADBEEF; end
      @(negedge clk); if (stallreq_o) stalls++;
      if (c == 0) begin
        n_total++; if ({dbus_cyc_o, dbus_we_o, dbus_sel_o} !== 6'b10_1111) $display("FAIL lw_req got %b exp 101111", {dbus_cyc_o, dbus_we_o, dbus_sel_o}); else n_pass++;
        n_total++; if (dbus_addr_o !== 32'h100) $display("FAIL lw_addr got %h exp 100", dbus_addr_o); else n_pass++;
      end
    end
    @(posedge clk); #1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    @(negedge clk); if (stallreq_o) stalls++;
    n_total++; if ({wreg_o, wdata_o, wd_o} !== {1'b1, 32'hDEADBEEF, 5'd5}) $display("FAIL lw_hold got %h exp %h", {wreg_o, wdata_o, wd_o}, {1'b1, 32'hDEADBEEF, 5'd5}); else n_pass++;
    n_total++; if (dbus_cyc_o !== 1'b0) $display("FAIL lw_cyc_drop got %b exp 0", dbus_cyc_o); else n_pass++;
    n_total++; if (stalls !== 4) $display("FAIL lw_stall_cycles got %0d exp 4", stalls); else n_pass++;
    @(posedge clk); #1; drive_idle();
  endtask

  task automatic test_subword_loads();
    logic [3:0] sel; logic we, wr, lw_, lv; logic [31:0] ba, bw, hd;
    run_access(MEMOP_LB, 32'h203, '0, 32'h0000_00F0, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if (sel !== 4'b0001) $display("FAIL lb_sel got %b exp 0001", sel); else n_pass++;
    n_total++; if (ba !== 32'h200) $display("FAIL lb_addr got %h exp 200", ba); else n_pass++;
    n_total++; if (hd !== 32'hFFFF_FFF0) $display("FAIL lb_data got %h exp fffffff0", hd); else n_pass++;
    run_access(MEMOP_LBU, 32'h203, '0, 32'h0000_00F0, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if (hd !== 32'h0000_00F0) $display("FAIL lbu_data got %h exp 000000f0", hd); else n_pass++;
    run_access(MEMOP_LH, 32'h102, '0, 32'h1234_8001, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({sel, hd} !== {4'b0011, 32'hFFFF_8001}) $display("FAIL lh_off2 got %h exp %h", {sel, hd}, {4'b0011, 32'hFFFF_8001}); else n_pass++;
    run_access(MEMOP_LHU, 32'h100, '0, 32'h8001_1234, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({sel, hd} !== {4'b1100, 32'h0000_8001}) $display("FAIL lhu_off0 got %h exp %h", {sel, hd}, {4'b1100, 32'h0000_8001}); else n_pass++;
  endtask

  task automatic test_stores();
    logic [3:0] sel; logic we, wr, lw_, lv; logic [31:0] ba, bw, hd;
    run_access(MEMOP_SB, 32'h201, 32'h1111_11AB, '0, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({we, sel, bw} !== {1'b1, 4'b0100, 32'hABAB_ABAB}) $display("FAIL sb_req got %h exp %h", {we, sel, bw}, {1'b1, 4'b0100, 32'hABAB_ABAB}); else n_pass++;
    n_total++; if (wr !== 1'b0) $display("FAIL sb_wreg got %b exp 0", wr); else n_pass++;
    run_access(MEMOP_SH, 32'h102, 32'h9999_1234, '0, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({we, sel, bw, ba} !== {1'b1, 4'b0011, 32'h1234_1234, 32'h100}) $display("FAIL sh_req got %h exp %h", {we, sel, bw, ba}, {1'b1, 4'b0011, 32'h1234_1234, 32'h100}); else n_pass++;
  endtask

  task automatic test_ll_sc();
    logic [3:0] sel; logic we, wr, lw_, lv; logic [31:0] ba, bw, hd;
    LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
    run_access(MEMOP_LL, 32'h40, '0, 32'h1122_3344, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({wr, hd, lw_, lv} !== {1'b1, 32'h1122_3344, 1'b1, 1'b1}) $display("FAIL ll_hold got %h exp %h", {wr, hd, lw_, lv}, {1'b1, 32'h1122_3344, 1'b1, 1'b1}); else n_pass++;
    wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
    run_access(MEMOP_SC, 32'h40, 32'hA5A5_A5A5, '0, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({we, sel, bw, ba} !== {1'b1, 4'hF, 32'hA5A5_A5A5, 32'h40}) $display("FAIL sc_req got %h exp %h", {we, sel, bw, ba}, {1'b1, 4'hF, 32'hA5A5_A5A5, 32'h40}); else n_pass++;
    n_total++; if ({wr, hd, lw_, lv} !== {1'b1, 32'h1, 1'b1, 1'b0}) $display("FAIL sc_ok_hold got %h exp %h", {wr, hd, lw_, lv}, {1'b1, 32'h1, 1'b1, 1'b0}); else n_pass++;
    wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0; LLbit_i = 1'b0;
    @(posedge clk); #1; drive_op(MEMOP_SC, 32'h40, 32'hA5A5_A5A5);
    @(negedge clk);
    n_total++; if ({wreg_o, wdata_o, LLbit_we_o, stallreq_o} !== {1'b1, 32'h0, 1'b0, 1'b0}) $display("FAIL sc_fail got %h exp %h", {wreg_o, wdata_o, LLbit_we_o, stallreq_o}, {1'b1, 32'h0, 1'b0, 1'b0}); else n_pass++;
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    n_total++; if (dbus_cyc_o !== 1'b0) $display("FAIL sc_fail_cyc got %b exp 0", dbus_cyc_o); else n_pass++;
    // register bit set but a pending write-back clears it: bypass must win
    LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
    @(posedge clk); #1; drive_op(MEMOP_SC, 32'h40, 32'h7);
    @(negedge clk);
    n_total++; if ({wreg_o, wdata_o, stallreq_o} !== {1'b1, 32'h0, 1'b0}) $display("FAIL sc_bypass got %h exp %h", {wreg_o, wdata_o, stallreq_o}, {1'b1, 32'h0, 1'b0}); else n_pass++;
    @(posedge clk); #1; drive_idle(); LLbit_i = 1'b0; wb_LLbit_we_i = 1'b0;
  endtask

  task automatic test_misalign();
    @(posedge clk); #1; drive_op(MEMOP_LH, 32'h101, '0);
    @(negedge clk);
    n_total++; if ({adel_o, ades_o, wreg_o, stallreq_o} !== 4'b1000) $display("FAIL lh_adel got %b exp 1000", {adel_o, ades_o, wreg_o, stallreq_o}); else n_pass++;
    @(posedge clk); #1; drive_op(MEMOP_SW, 32'h102, 32'h1);
    @(negedge clk);
    n_total++; if ({adel_o, ades_o, wreg_o, stallreq_o, dbus_cyc_o} !== 5'b01000) $display("FAIL sw_ades got %b exp 01000", {adel_o, ades_o, wreg_o, stallreq_o, dbus_cyc_o}); else n_pass++;
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    n_total++; if ({adel_o, ades_o, dbus_cyc_o} !== 3'b000) $display("FAIL misalign_after got %b exp 000", {adel_o, ades_o, dbus_cyc_o}); else n_pass++;
  endtask

  task automatic test_flush();
    logic [3:0] sel; logic we, wr, lw_, lv; logic [31:0] ba, bw, hd;
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0); flush = 1'b1;
    @(negedge clk);
    n_total++; if ({stallreq_o, wreg_o} !== 2'b00) $display("FAIL flush_idle got %b exp 00", {stallreq_o, wreg_o}); else n_pass++;
    @(posedge clk); #1; flush = 1'b0; drive_idle();
    @(negedge clk);
    n_total++; if (dbus_cyc_o !== 1'b0) $display("FAIL flush_idle_cyc got %b exp 0", dbus_cyc_o); else n_pass++;
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0);
    @(negedge clk);
    @(posedge clk); #1; flush = 1'b1;
    @(negedge clk);
    n_total++; if ({dbus_cyc_o, stallreq_o, wreg_o} !== 3'b110) $display("FAIL flush_bus got %b exp 110", {dbus_cyc_o, stallreq_o, wreg_o}); else n_pass++;
    @(posedge clk); #1; flush = 1'b0;
    @(posedge clk); #1; dbus_ack_i = 1'b1; dbus_rdata_i = 32'h1234_5678;
    @(posedge clk); #1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    @(negedge clk);
    n_total++; if ({wreg_o, LLbit_we_o, stallreq_o, dbus_cyc_o} !== 4'b0000) $display("FAIL flush_hold got %b exp 0000", {wreg_o, LLbit_we_o, stallreq_o, dbus_cyc_o}); else n_pass++;
    @(posedge clk); #1; drive_idle();
    run_access(MEMOP_LW, 32'h104, '0, 32'h77, sel, we, ba, bw, wr, hd, lw_, lv);
    n_total++; if ({wr, hd} !== {1'b1, 32'h77}) $display("FAIL kill_cleared got %h exp %h", {wr, hd}, {1'b1, 32'h77}); else n_pass++;
  endtask

  task automatic test_timeout();
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (c < 4) begin
        n_total++; if ({buserr_o, stallreq_o} !== 2'b01) $display("FAIL to_wait%0d got %b exp 01", c, {buserr_o, stallreq_o}); else n_pass++;
      end else begin
        n_total++; if ({buserr_o, stallreq_o, wreg_o} !== 3'b100) $display("FAIL to_fire got %b exp 100", {buserr_o, stallreq_o, wreg_o}); else n_pass++;
      end
    end
    @(posedge clk); #1; drive_idle();
    @(negedge clk);
    n_total++; if ({dbus_cyc_o, buserr_o} !== 2'b00) $display("FAIL to_after got %b exp 00", {dbus_cyc_o, buserr_o}); else n_pass++;
  endtask

  task automatic test_ack_wins();
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0);
    @(negedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin dbus_ack_i = 1'b1; dbus_rdata_i = 32'h0BAD_F00D; end
      @(negedge clk);
    end
    n_total++; if ({buserr_o, stallreq_o} !== 2'b01) $display("FAIL ackwin_term got %b exp 01", {buserr_o, stallreq_o}); else n_pass++;
    @(posedge clk); #1; dbus_ack_i = 1'b0; dbus_rdata_i = '0;
    @(negedge clk);
    n_total++; if ({wreg_o, wdata_o} !== {1'b1, 32'h0BAD_F00D}) $display("FAIL ackwin_hold got %h exp %h", {wreg_o, wdata_o}, {1'b1, 32'h0BAD_F00D}); else n_pass++;
    @(posedge clk); #1; drive_idle();
  endtask

  task automatic test_reset_mid_bus();
    @(posedge clk); #1; drive_op(MEMOP_LW, 32'h100, '0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (dbus_cyc_o !== 1'b1) $display("FAIL rstbus_pre got %b exp 1", dbus_cyc_o); else n_pass++;
    @(posedge clk); #1; rst = 1'b0;
    #1;
    n_total++; if ({dbus_cyc_o, stallreq_o} !== 2'b00) $display("FAIL rstbus_async got %b exp 00", {dbus_cyc_o, stallreq_o}); else n_pass++;
    @(posedge clk); #1; drive_idle(); rst = 1'b1;
    @(negedge clk);
    n_total++; if ({dbus_cyc_o, stallreq_o} !== 2'b00) $display("FAIL rstbus_after got %b exp 00", {dbus_cyc_o, stallreq_o}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_subword_loads();
    test_stores();
    test_ll_sc();
    test_misalign();
    test_flush();
    test_timeout();
    test_ack_wins();
    test_reset_mid_bus();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
